dircc_counter_send_handler: RTL and testbench
=============================================

# dircc_counter_send_handler

Transmit-side handler for the counter application in the DiRCC processing element; pairs with the receive handler. On a scheduler send request it checks the device's ready-to-send (`rts`) count, emits one tick packet with a valid/ready handshake, and writes back the device state with `rts` decremented. It sits between the device-state memory port and the outbound packet interface of the processing counter.

## Interface

- `ADDRESS_MEM_WIDTH`, default 32, width of the device/thread address.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  ADDRESS_MEM_WIDTH  device address; sampled with `send_request`, informational only (no context lookup).
- `send_request`  in  1  single-cycle request to attempt one send; honoured only in IDLE.
- `read_state`  in  device_state_t  current device state; `user_state[31:16]` = rts, `user_state[15:0]` = count (unsigned).
- `packet_out`  out  packet_data_t  tick message; payload = captured count zero-extended to PACKET_DATA_WIDTH.
- `packet_out_valid`  out  1  packet valid.
- `packet_out_ready`  in  1  downstream accepts packet when high together with valid.
- `write_state`  out  device_state_t  updated device state.
- `write_state_valid`  out  1  one-cycle write strobe for `write_state`.
- `send_done`  out  1  one-cycle pulse: request completed (sent or skipped).
- `send_skipped`  out  1  qualifies `send_done`: 1 = no packet sent.

## Operation

- FSM states: IDLE, SEND, UPDATE, SKIP.
- IDLE: on `send_request`, capture `read_state` into an internal snapshot. If snapshot rts == 0 or `dircc_state` has DIRCC_STATE_STOPPED or DIRCC_STATE_DONE set → SKIP; else → SEND.
- SEND: `packet_out_valid`=1, `packet_out` = snapshot count (zero-extended). Packet held stable until `packet_out_valid && packet_out_ready`; on that cycle → UPDATE. No timeout; valid never drops without handshake except on reset.
- UPDATE (one cycle): `write_state_valid`=1, `send_done`=1, `send_skipped`=0. `write_state.user_state` = {zeros, rts-1, count}; `dircc_state` and `dircc_state_extra` copied from snapshot. → IDLE.
- SKIP (one cycle): `send_done`=1, `send_skipped`=1, `write_state_valid`=0, no packet. → IDLE.
- Arithmetic: rts is 16-bit unsigned; decrement happens only when rts ≥ 1, so it never wraps. count is never modified by this block.
- `send_request` outside IDLE is ignored (not queued).
- `read_state` changes after capture have no effect on the in-flight packet or write-back.
- Reset: state → IDLE; `packet_out_valid`, `write_state_valid`, `send_done`, `send_skipped` = 0; `packet_out` = 0; `write_state` = 0; snapshot cleared. Reset during SEND drops valid on the next cycle without completing the handshake and without a write-back.

## Timing

- Request sampled at edge N → `packet_out_valid` high from cycle N+1 (registered output).
- Handshake at edge M (valid && ready) → cycle M+1: valid low, `write_state_valid`=1, `send_done`=1.
- Ready held high: request→done = 2 cycles; next request accepted at edge M+2 (2-cycle minimum spacing = 3-cycle period).
- Skip path: request at edge N → `send_done`/`send_skipped` in cycle N+1; IDLE again at N+2.
- All outputs registered; no combinational path from `packet_out_ready` to any output.

## Test plan

- Reset then request with rts=3, count=7, ready=1 → packet payload 7 one cycle after request, then `write_state_valid` with rts=2, count=7, `send_done`=1, `send_skipped`=0.
- Request with rts=0, count=5 → no `packet_out_valid`, `send_done`=1 and `send_skipped`=1 next cycle, no write strobe.
- Request with rts=1, ready low for 4 cycles → valid and payload stable for 5 cycles, handshake on 5th, write-back rts=0; second request mid-stall ignored.
- Request with `dircc_state` = DONE|STOPPED, rts=4 → skip path, no packet, no write.
- Assert `reset` while in SEND with ready low → valid 0 the following cycle, no `write_state_valid`/`send_done`; fresh request afterwards sends normally.
- Change `read_state` count from 9 to 10 the cycle after request → packet payload 9, write-back count 9.

Source files
------------

// File: rtl/dircc_counter_send_handler.sv
// Transmit-side handler for the DiRCC counter application: sends one tick packet
// per request while rts > 0, then writes the device state back with rts decremented.

package dircc_counter_pkg;
  localparam int PACKET_DATA_WIDTH = 32;

  localparam logic [7:0] DIRCC_STATE_STOPPED = 8'h01;
  localparam logic [7:0] DIRCC_STATE_DONE    = 8'h02;

  typedef logic [PACKET_DATA_WIDTH-1:0] packet_data_t;

  typedef struct packed {
    logic [7:0]  dircc_state;
    logic [23:0] dircc_state_extra;
    logic [63:0] user_state;
  } device_state_t;
endpackage

module dircc_counter_send_handler
  import dircc_counter_pkg::*;
#(
  parameter int ADDRESS_MEM_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  logic                         send_request,
  input  device_state_t                read_state,
  output packet_data_t                 packet_out,
  output logic                         packet_out_valid,
  input  logic                         packet_out_ready,
  output device_state_t                write_state,
  output logic                         write_state_valid,
  output logic                         send_done,
  output logic                         send_skipped
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_SKIP   = 2'd3;

  logic [1:0]   state_reg;
  logic [7:0]   snap_flags_reg;
  logic [23:0]  snap_extra_reg;
  logic [15:0]  snap_rts_reg;
  logic [15:0]  snap_count_reg;
  packet_data_t packet_out_reg;
  logic         packet_out_valid_reg;
  device_state_t write_state_reg;
  logic         write_state_valid_reg;
  logic         send_done_reg;
  logic         send_skipped_reg;

  logic         skip_next;

  // The address and the upper user_state word are carried for context only.
  logic unused_inputs;
  assign unused_inputs = ^{address, read_state.user_state[63:32]};

  assign skip_next = (read_state.user_state[31:16] == 16'd0) ||
                     ((read_state.dircc_state & (DIRCC_STATE_STOPPED | DIRCC_STATE_DONE)) != 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg             <= ST_IDLE;
      snap_flags_reg        <= '0;
      snap_extra_reg        <= '0;
      snap_rts_reg          <= '0;
      snap_count_reg        <= '0;
      packet_out_reg        <= '0;
      packet_out_valid_reg  <= 1'b0;
      write_state_reg       <= '0;
      write_state_valid_reg <= 1'b0;
      send_done_reg         <= 1'b0;
      send_skipped_reg      <= 1'b0;
    end else begin
      write_state_valid_reg <= 1'b0;
      send_done_reg         <= 1'b0;
      send_skipped_reg      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (send_request) begin
            snap_flags_reg <= read_state.dircc_state;
            snap_extra_reg <= read_state.dircc_state_extra;
            snap_rts_reg   <= read_state.user_state[31:16];
            snap_count_reg <= read_state.user_state[15:0];
            if (skip_next) begin
              state_reg        <= ST_SKIP;
              send_done_reg    <= 1'b1;
              send_skipped_reg <= 1'b1;
            end else begin
              state_reg            <= ST_SEND;
              packet_out_valid_reg <= 1'b1;
              packet_out_reg       <= {{(PACKET_DATA_WIDTH-16){1'b0}}, read_state.user_state[15:0]};
            end
          end
        end
        ST_SEND: begin
          // rts was checked non-zero on entry, so the decrement cannot wrap.
          if (packet_out_ready) begin
            state_reg                            <= ST_UPDATE;
            packet_out_valid_reg                 <= 1'b0;
            write_state_reg.dircc_state          <= snap_flags_reg;
            write_state_reg.dircc_state_extra    <= snap_extra_reg;
            write_state_reg.user_state           <= {32'd0, snap_rts_reg - 16'd1, snap_count_reg};
            write_state_valid_reg                <= 1'b1;
            send_done_reg                        <= 1'b1;
          end
        end
        ST_UPDATE: state_reg <= ST_IDLE;
        ST_SKIP:   state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  assign packet_out        = packet_out_reg;
  assign packet_out_valid  = packet_out_valid_reg;
  assign write_state       = write_state_reg;
  assign write_state_valid = write_state_valid_reg;
  assign send_done         = send_done_reg;
  assign send_skipped      = send_skipped_reg;

endmodule

// File: tb/tb_dircc_counter_send_handler.sv
// Directed self-checking bench for dircc_counter_send_handler.
`timescale 1ns/1ps
module tb_dircc_counter_send_handler;
  import dircc_counter_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   address;
  logic          send_request;
  device_state_t read_state;
  packet_data_t  packet_out;
  logic          packet_out_valid;
  logic          packet_out_ready;
  device_state_t write_state;
  logic          write_state_valid;
  logic          send_done;
  logic          send_skipped;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dircc_counter_send_handler #(.ADDRESS_MEM_WIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .address          (address),
    .send_request     (send_request),
    .read_state       (read_state),
    .packet_out       (packet_out),
    .packet_out_valid (packet_out_valid),
    .packet_out_ready (packet_out_ready),
    .write_state      (write_state),
    .write_state_valid(write_state_valid),
    .send_done        (send_done),
    .send_skipped     (send_skipped)
  );

  // Upper user_state word is deliberately non-zero; write-back must clear it.
  function automatic device_state_t mk(input logic [7:0] flags, input logic [15:0] rts,
                                       input logic [15:0] count);
    device_state_t s;
    s.dircc_state       = flags;
    s.dircc_state_extra = 24'hA5A5A5;
    s.user_state        = {32'hDEADBEEF, rts, count};
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_request();
    send_request = 1'b1;
    step();
    send_request = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; send_request = 1'b0; packet_out_ready = 1'b0;
    address = 32'h0; read_state = '0;
    step(); step(); step();
    reset = 1'b0;
    n_cmp++; if (packet_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", packet_out_valid); end
    n_cmp++; if (packet_out !== 32'h0) begin n_err++; $display("FAIL reset_packet: got %h want 0", packet_out); end
    n_cmp++; if (write_state_valid !== 1'b0) begin n_err++; $display("FAIL reset_wsv: got %b want 0", write_state_valid); end
    n_cmp++; if (write_state !== 128'h0) begin n_err++; $display("FAIL reset_ws: got %h want 0", write_state); end
    n_cmp++; if ({send_done, send_skipped} !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", {send_done, send_skipped}); end
    $display("[%0t] reset checked", $time);
  endtask

  task automatic test_send_basic();
    read_state = mk(8'h10, 16'd3, 16'd7); address = 32'h100; packet_out_ready = 1'b1;
    pulse_request();
    n_cmp++; if (packet_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", packet_out_valid); end
    n_cmp++; if (packet_out !== 32'd7) begin n_err++; $display("FAIL basic_payload: got %h want 7", packet_out); end
    n_cmp++; if (write_state_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_wsv: got %b want 0", write_state_valid); end
    step();
    n_cmp++; if (packet_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_drop: got %b want 0", packet_out_valid); end
    n_cmp++; if (write_state_valid !== 1'b1) begin n_err++; $display("FAIL basic_wsv: got %b want 1", write_state_valid); end
    n_cmp++; if ({send_done, send_skipped} !== 2'b10) begin n_err++; $display("FAIL basic_done: got %b want 10", {send_done, send_skipped}); end
    n_cmp++; if (write_state !== {8'h10, 24'hA5A5A5, 32'h0, 16'd2, 16'd7}) begin n_err++; $display("FAIL basic_ws: got %h want %h", write_state, {8'h10, 24'hA5A5A5, 32'h0, 16'd2, 16'd7}); end
    step();
    n_cmp++; if ({write_state_valid, send_done} !== 2'b00) begin n_err++; $display("FAIL basic_strobe_len: got %b want 00", {write_state_valid, send_done}); end
    $display("[%0t] send rts=3 count=7 -> payload %0d", $time, packet_out);
  endtask

  task automatic test_skip_rts0();
    read_state = mk(8'h00, 16'd0, 16'd5); packet_out_ready = 1'b1;
    pulse_request();
    n_cmp++; if (packet_out_valid !== 1'b0) begin n_err++; $display("FAIL skip0_valid: got %b want 0", packet_out_valid); end
    n_cmp++; if ({send_done, send_skipped} !== 2'b11) begin n_err++; $display("FAIL skip0_done: got %b want 11", {send_done, send_skipped}); end
    n_cmp++; if (write_state_valid !== 1'b0) begin n_err++; $display("FAIL skip0_wsv: got %b want 0", write_state_valid); end
    step();
    n_cmp++; if ({send_done, send_skipped, packet_out_valid} !== 3'b000) begin n_err++; $display("FAIL skip0_after: got %b want 000", {send_done, send_skipped, packet_out_valid}); end
    $display("[%0t] skip rts=0", $time);
  endtask

  task automatic test_stall();
    read_state = mk(8'h00, 16'd1, 16'h1234); packet_out_ready = 1'b0;
    pulse_request();
    for (int i = 1; i <= 5; i++) begin
      n_cmp++; if (packet_out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid_c%0d: got %b want 1", i, packet_out_valid); end
      n_cmp++; if (packet_out !== 32'h1234) begin n_err++; $display("FAIL stall_payload_c%0d: got %h want 1234", i, packet_out); end
      if (i == 2) begin
        read_state = mk(8'h00, 16'd5, 16'h0055);
        send_request = 1'b1;
      end else begin
        send_request = 1'b0;
      end
      if (i == 5) packet_out_ready = 1'b1;
      if (i < 5) begin
        step();
      end
    end
    step();
    n_cmp++; if ({write_state_valid, send_done, send_skipped} !== 3'b110) begin n_err++; $display("FAIL stall_done: got %b want 110", {write_state_valid, send_done, send_skipped}); end
    n_cmp++; if (write_state.user_state !== {32'h0, 16'd0, 16'h1234}) begin n_err++; $display("FAIL stall_ws: got %h want %h", write_state.user_state, {32'h0, 16'd0, 16'h1234}); end
    step(); step();
    n_cmp++; if ({packet_out_valid, send_done} !== 2'b00) begin n_err++; $display("FAIL stall_no_requeue: got %b want 00", {packet_out_valid, send_done}); end
    $display("[%0t] stalled send rts=1 count=0x1234", $time);
  endtask

  task automatic test_stopped_done();
    read_state = mk(DIRCC_STATE_DONE | DIRCC_STATE_STOPPED, 16'd4, 16'd2); packet_out_ready = 1'b1;
    pulse_request();
    n_cmp++; if ({packet_out_valid, write_state_valid} !== 2'b00) begin n_err++; $display("FAIL stopdone_nosend: got %b want 00", {packet_out_valid, write_state_valid}); end
    n_cmp++; if ({send_done, send_skipped} !== 2'b11) begin n_err++; $display("FAIL stopdone_done: got %b want 11", {send_done, send_skipped}); end
    step();
    read_state = mk(DIRCC_STATE_STOPPED, 16'd4, 16'd2);
    pulse_request();
    n_cmp++; if ({packet_out_valid, send_done, send_skipped} !== 3'b011) begin n_err++; $display("FAIL stopped_only: got %b want 011", {packet_out_valid, send_done, send_skipped}); end
    step();
    $display("[%0t] skip on DONE/STOPPED", $time);
  endtask

  task automatic test_reset_in_send();
    read_state = mk(8'h00, 16'd6, 16'd11); packet_out_ready = 1'b0;
    pulse_request();
    n_cmp++; if (packet_out_valid !== 1'b1) begin n_err++; $display("FAIL rsend_valid: got %b want 1", packet_out_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if ({packet_out_valid, write_state_valid, send_done} !== 3'b000) begin n_err++; $display("FAIL rsend_drop: got %b want 000", {packet_out_valid, write_state_valid, send_done}); end
    packet_out_ready = 1'b1;
    step();
    n_cmp++; if ({write_state_valid, send_done} !== 2'b00) begin n_err++; $display("FAIL rsend_no_wb: got %b want 00", {write_state_valid, send_done}); end
    pulse_request();
    n_cmp++; if (packet_out !== 32'd11 || packet_out_valid !== 1'b1) begin n_err++; $display("FAIL rsend_fresh_pkt: got %b/%h want 1/b", packet_out_valid, packet_out); end
    step();
    n_cmp++; if (write_state.user_state !== {32'h0, 16'd5, 16'd11} || write_state_valid !== 1'b1) begin n_err++; $display("FAIL rsend_fresh_ws: got %b/%h want 1/%h", write_state_valid, write_state.user_state, {32'h0, 16'd5, 16'd11}); end
    step();
    $display("[%0t] reset during SEND then fresh send", $time);
  endtask

  task automatic test_capture();
    read_state = mk(8'h20, 16'd2, 16'd9); packet_out_ready = 1'b0;
    pulse_request();
    read_state = mk(8'h40, 16'd8, 16'd10);
    step();
    n_cmp++; if (packet_out !== 32'd9) begin n_err++; $display("FAIL capture_payload: got %0d want 9", packet_out); end
    packet_out_ready = 1'b1;
    step();
    n_cmp++; if (write_state !== {8'h20, 24'hA5A5A5, 32'h0, 16'd1, 16'd9}) begin n_err++; $display("FAIL capture_ws: got %h want %h", write_state, {8'h20, 24'hA5A5A5, 32'h0, 16'd1, 16'd9}); end
    step();
    $display("[%0t] snapshot isolation count 9", $time);
  endtask

  task automatic test_back_to_back();
    read_state = mk(8'h00, 16'd9, 16'd3); packet_out_ready = 1'b1;
    send_request = 1'b1;
    step();
    n_cmp++; if (packet_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %b want 1", packet_out_valid); end
    step();
    n_cmp++; if ({packet_out_valid, send_done} !== 2'b01) begin n_err++; $display("FAIL b2b_done: got %b want 01", {packet_out_valid, send_done}); end
    step();
    n_cmp++; if ({packet_out_valid, send_done} !== 2'b00) begin n_err++; $display("FAIL b2b_gap: got %b want 00", {packet_out_valid, send_done}); end
    step();
    send_request = 1'b0;
    n_cmp++; if (packet_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %b want 1", packet_out_valid); end
    step(); step();
    $display("[%0t] back-to-back requests, 3-cycle period", $time);
  endtask

  initial begin
    test_reset();
    test_send_basic();
    test_skip_rts0();
    test_stall();
    test_stopped_done();
    test_reset_in_send();
    test_capture();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
